// File: rtl/seq_bin2bcd.sv
// -----------------------------------------------------------------------------
// seq_bin2bcd
//   Iterative shift-add-3 (double-dabble) binary-to-BCD converter. One input
//   bit is consumed per clock; the last result is held stable for the seg7
//   display driver until the next conversion completes.
//
//   Optional feature macro: BCD_BLANK_EN (adds the leading-zero mask 'blank').
//
// Ports
//   clk_25mhz  in   1          system clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          request: bin is valid
//   in_ready   out  1          converter idle, request accepted this cycle
//   bin        in   BIN_W      unsigned binary operand
//   out_valid  out  1          one-cycle pulse: bcd/ovf(/blank) updated
//   busy       out  1          conversion in progress (SHIFT state)
//   bcd        out  4*DIGITS   packed BCD, digit 0 = bcd[3:0] (units)
//   ovf        out  1          last operand >= 10**DIGITS
//   blank      out  DIGITS     leading-zero mask (BCD_BLANK_EN only)
// -----------------------------------------------------------------------------
module seq_bin2bcd #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk_25mhz,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  // One extra carry digit on top so digits beyond DIGITS are computed and
  // then simply discarded (overflow keeps the low digits of the true result).
  localparam int          SCR_W    = 4*DIGITS + 4;
  localparam int          CNT_W    = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT    = 64'd10 ** DIGITS;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [BIN_W-1:0]      bin_q,  bin_d;
  logic [SCR_W-1:0]      scr_q,  scr_d;
  logic [SCR_W-1:0]      adj;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_next_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  ovf_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  in_ready_q;
  logic                  unused_carry_msb;

  // One double-dabble step: correct each real digit, then shift in the next
  // operand bit. The carry digit is never corrected; its MSB falls off.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_d = {adj[SCR_W-2:0], bin_q[BIN_W-1]};
    bin_d = bin_q << 1;
  end

  assign unused_carry_msb = adj[SCR_W-1];

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_above;

  // Bit i blanks digit i when it and every more-significant digit are zero;
  // the units digit is never blanked.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (scr_q[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end
`endif

  // NOTE: all state lives in this one clocked block and is assigned with
  // non-blocking '<=' so every register samples pre-edge values; blocking '='
  // here would make results depend on statement order.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      scr_q       <= '0;
      cnt_q       <= '0;
      ovf_next_q  <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef BCD_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            bin_q      <= bin;
            scr_q      <= '0;
            cnt_q      <= CNT_INIT;
            ovf_next_q <= (64'(bin) >= LIMIT);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - 1'b1;
          // Counter at 1 means this edge performs the final shift.
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_q       <= scr_q[4*DIGITS-1:0];
          ovf_q       <= ovf_next_q;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
`ifdef BCD_BLANK_EN
          blank_q     <= blank_d;
`endif
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd       = bcd_q;
  assign ovf       = ovf_q;
`ifdef BCD_BLANK_EN
  assign blank     = blank_q;
`endif

endmodule
